mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Control FSM for the shift-and-add multiplier datapath. On a `start` request it sequences the operand registers and the product accumulator through their enable and active-low synchronous-clear inputs: load, then `WORD_LENGTH` add/shift rounds, then a done pulse. It sits between the top-level request interface and the datapath registers, which share its `clk` and `reset`.

## Interface
- `WORD_LENGTH`, default 4: operand width in bits; sets the number of add/shift rounds.
- `CNT_W`, default `$clog2(WORD_LENGTH)+1`: width of the round counter.

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  multiplication request; sampled in IDLE only
- `abort`  in  1  synchronous cancel; honoured in every state
- `multiplier_lsb`  in  1  bit 0 of the shifting multiplier register
- `operand_enable`  out  1  enable for the multiplicand/multiplier registers
- `operand_sync_reset_n`  out  1  active-low sync clear for the operand registers; effective only with `operand_enable`=1
- `shift_enable`  out  1  multiplicand shifts left and multiplier shifts right this cycle
- `product_enable`  out  1  enable for the product accumulator
- `product_sync_reset_n`  out  1  active-low sync clear for the product accumulator; effective only with `product_enable`=1
- `round`  out  `CNT_W`  current round index, 0..`WORD_LENGTH`-1
- `busy`  out  1  high in LOAD and RUN
- `ready`  out  1  one-cycle pulse: the product is valid

## Operation
- The FSM has four states: IDLE, LOAD, RUN and DONE.
- Reset values: state IDLE and `round`=0. All enables are 0, both `*_sync_reset_n` are 1, and `busy`=`ready`=0.
- IDLE
  - Outputs are at their reset values.
  - If `start`=1 and `abort`=0, go to LOAD.
- LOAD (one cycle)
  - `operand_enable`=1 and `operand_sync_reset_n`=1, so the operands latch.
  - `product_enable`=1 and `product_sync_reset_n`=0, so the product clears.
  - `busy`=1 and `round` is cleared to 0. Go to RUN.
- RUN (exactly `WORD_LENGTH` cycles)
  - `shift_enable`=1 and `busy`=1.
  - `product_enable`=`multiplier_lsb`. This is the only Mealy output: the accumulator adds the shifted multiplicand only when the LSB is 1. `product_sync_reset_n`=1.
  - `round` increments each cycle.
  - When `round`=`WORD_LENGTH`-1, go to DONE and reset `round` to 0.
- DONE (one cycle)
  - `ready`=1 and `busy`=0. All enables are 0, so the product holds.
  - Go to IDLE.
- `abort`=1 at any clock edge
  - The next state is IDLE and `round`=0.
  - No `ready` pulse is issued for the cancelled operation.
  - `abort` has priority over `start`.
  - The product register is not cleared; its contents are undefined to the user until the next LOAD.
- `start` is ignored outside IDLE and is not queued. A `start` held high restarts on the first IDLE cycle after DONE.
- Asynchronous `reset` mid-operation returns the FSM to IDLE with reset values immediately, with no `ready` pulse.
- `WORD_LENGTH`=1 is legal: RUN lasts one cycle.

## Timing
- `start` is sampled high at edge E0.
  - LOAD occupies cycle E0–E1.
  - RUN occupies E1..E(1+`WORD_LENGTH`).
  - `ready` is high during cycle E(1+`WORD_LENGTH`)..E(2+`WORD_LENGTH`).
- Latency from `start` to `ready` is `WORD_LENGTH`+2 cycles: 6 cycles for `WORD_LENGTH`=4.
- Back-to-back throughput is one operation per `WORD_LENGTH`+3 cycles, because of the mandatory IDLE cycle.
- All outputs except `product_enable` in RUN are registered-state decodes, with no combinational path from inputs.
- `product_enable` in RUN has a combinational path from `multiplier_lsb`. The datapath must present the LSB of the already-shifted value each cycle.

## Test plan
All scenarios use `WORD_LENGTH`=4.
- **Reset:** assert `reset`=0 mid-RUN → next sample shows `busy`=0, `ready`=0, `round`=0, all enables 0, both `*_sync_reset_n`=1.
- **Single operation:** 1-cycle `start` pulse with `multiplier_lsb` sequence 1,0,1,1 in RUN →
  - LOAD cycle has `product_sync_reset_n`=0 with `product_enable`=1.
  - `product_enable` is 1,0,1,1 across the 4 RUN cycles and `shift_enable`=1 throughout.
  - `ready` pulses exactly once, 6 cycles after `start` is sampled.
- **End-to-end with datapath:** 4'd13 × 4'd11 → product 8'd143 at `ready`. Also 4'd15 × 4'd15 → 8'd225, and 4'd0 × 4'd9 → 0 with `product_enable` never high in RUN.
- **Start while busy:** pulse `start` during RUN round 2 → ignored; exactly one `ready` is seen. With `start` held high continuously → a `ready` pulse every 7 cycles.
- **Abort:** `abort`=1 in RUN round 1 → IDLE on the next cycle and no `ready`. Abort in DONE → no effect beyond the IDLE transition. `abort` and `start` high together in IDLE → stays in IDLE.
- **Counter wrap:** verify `round` runs 0,1,2,3 in RUN and is 0 in DONE and IDLE, and that exactly 4 cycles have `shift_enable`=1.

Source files
------------

// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM for a shift-and-add multiplier datapath.
// Sequences operand load / product clear, WORD_LENGTH add-shift rounds,
// then a one-cycle ready pulse. abort cancels from any state.
module mult_sequencer #(
  parameter int WORD_LENGTH = 4,
  parameter int CNT_W       = $clog2(WORD_LENGTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             multiplier_lsb,
  output logic             operand_enable,
  output logic             operand_sync_reset_n,
  output logic             shift_enable,
  output logic             product_enable,
  output logic             product_sync_reset_n,
  output logic [CNT_W-1:0] round,
  output logic             busy,
  output logic             ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(WORD_LENGTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_round;
  logic [CNT_W-1:0] w_round_next;

  // State and round counter registers; async active-low reset to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_round <= '0;
    end else begin
      r_state <= w_state_next;
      r_round <= w_round_next;
    end
  end

  // Next-state and next-round logic; abort overrides every transition.
  always_comb begin
    w_state_next = r_state;
    w_round_next = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (r_round == LAST_ROUND) begin
          w_state_next = S_DONE;
        end else begin
          w_round_next = r_round + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
      w_round_next = '0;
    end
  end

  // Output decode from the registered state; product_enable in RUN follows the LSB.
  always_comb begin
    operand_enable       = 1'b0;
    operand_sync_reset_n = 1'b1;
    shift_enable         = 1'b0;
    product_enable       = 1'b0;
    product_sync_reset_n = 1'b1;
    busy                 = 1'b0;
    ready                = 1'b0;
    case (r_state)
      S_LOAD: begin
        operand_enable       = 1'b1;
        product_enable       = 1'b1;
        product_sync_reset_n = 1'b0;
        busy                 = 1'b1;
      end
      S_RUN: begin
        shift_enable   = 1'b1;
        product_enable = multiplier_lsb;
        busy           = 1'b1;
      end
      S_DONE: begin
        ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign round = r_round;

endmodule

// File: tb/tb_mult_sequencer.sv
// Testbench for mult_sequencer: directed scenarios plus random start/abort
// traffic, checked against a schedule-based reference model and a small
// shift-and-add datapath built around the sequencer.
module tb_mult_sequencer;

  localparam int WL    = 4;
  localparam int CNT_W = $clog2(WL) + 1;

  localparam int K_IDLE = 0;
  localparam int K_LOAD = 1;
  localparam int K_RUN  = 2;
  localparam int K_DONE = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic             multiplier_lsb;
  logic             operand_enable;
  logic             operand_sync_reset_n;
  logic             shift_enable;
  logic             product_enable;
  logic             product_sync_reset_n;
  logic [CNT_W-1:0] round;
  logic             busy;
  logic             ready;

  mult_sequencer #(.WORD_LENGTH(WL)) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .abort                (abort),
    .multiplier_lsb       (multiplier_lsb),
    .operand_enable       (operand_enable),
    .operand_sync_reset_n (operand_sync_reset_n),
    .shift_enable         (shift_enable),
    .product_enable       (product_enable),
    .product_sync_reset_n (product_sync_reset_n),
    .round                (round),
    .busy                 (busy),
    .ready                (ready)
  );

  always #5 clk = ~clk;

  // Datapath model driven by the sequencer outputs.
  logic [WL-1:0]   op_a;
  logic [WL-1:0]   op_b;
  logic [2*WL-1:0] dp_mcand;
  logic [WL-1:0]   dp_mplier;
  logic [2*WL-1:0] dp_product;

  assign multiplier_lsb = dp_mplier[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_mcand   <= '0;
      dp_mplier  <= '0;
      dp_product <= '0;
    end else begin
      if (operand_enable) begin
        dp_mcand  <= operand_sync_reset_n ? {{WL{1'b0}}, op_a} : '0;
        dp_mplier <= operand_sync_reset_n ? op_b : '0;
      end else if (shift_enable) begin
        dp_mcand  <= dp_mcand << 1;
        dp_mplier <= dp_mplier >> 1;
      end
      if (product_enable) begin
        dp_product <= product_sync_reset_n ? dp_product + dp_mcand : '0;
      end
    end
  end

  // Reference model: an accepted request schedules LOAD, WL rounds, DONE.
  typedef struct {
    int kind;
    int rnd;
    int prod;
  } rec_t;

  rec_t q[$];
  rec_t cur;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int ready_cnt = 0;
  int shift_cnt = 0;
  int ready_at[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r.kind = K_IDLE;
    r.rnd  = 0;
    r.prod = 0;
    return r;
  endfunction

  task automatic model_step(input logic st, input logic ab);
    rec_t r;
    if (ab) begin
      q.delete();
      cur = idle_rec();
    end else if (cur.kind == K_IDLE && st) begin
      q.delete();
      r.prod = int'(op_a) * int'(op_b);
      r.kind = K_LOAD;
      r.rnd  = 0;
      q.push_back(r);
      for (int i = 0; i < WL; i++) begin
        r.kind = K_RUN;
        r.rnd  = i;
        q.push_back(r);
      end
      r.kind = K_DONE;
      r.rnd  = 0;
      q.push_back(r);
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = idle_rec();
    end
  endtask

  // Compare all outputs with the model for the current cycle.
  task automatic check_outputs();
    logic [6:0] exp_v;
    logic [6:0] obs_v;
    // {operand_enable, operand_sync_reset_n, shift_enable, product_enable,
    //  product_sync_reset_n, busy, ready}
    case (cur.kind)
      K_LOAD:  exp_v = 7'b1101010;
      K_RUN:   exp_v = {3'b011, multiplier_lsb, 3'b110};
      K_DONE:  exp_v = 7'b0100101;
      default: exp_v = 7'b0100100;
    endcase
    obs_v = {operand_enable, operand_sync_reset_n, shift_enable, product_enable,
             product_sync_reset_n, busy, ready};
    check_val("outputs", 32'(obs_v), 32'(exp_v));
    check_val("round", 32'(round), 32'(cur.rnd));
    if (cur.kind == K_DONE) begin
      check_val("product", 32'(dp_product), 32'(cur.prod));
    end
    if (ready) begin
      ready_cnt++;
      ready_at.push_back(cyc);
    end
    if (shift_enable) shift_cnt++;
  endtask

  task automatic cycle(input logic st, input logic ab);
    start = st;
    abort = ab;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step(st, ab);
    #1;
    cyc++;
  endtask

  task automatic clear_counts();
    ready_cnt = 0;
    shift_cnt = 0;
    ready_at.delete();
  endtask

  task automatic run_op(input logic [WL-1:0] a, input logic [WL-1:0] b, input string tag);
    int s;
    op_a = a;
    op_b = b;
    clear_counts();
    s = cyc;
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    check_val({tag, "_ready_cnt"}, 32'(ready_cnt), 32'd1);
    check_val({tag, "_shift_cnt"}, 32'(shift_cnt), 32'(WL));
    if (ready_at.size() > 0) check_val({tag, "_latency"}, 32'(ready_at[0] - s), 32'(WL + 2));
  endtask

  task automatic do_reset();
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    q.delete();
    cur = idle_rec();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc++;
  endtask

  initial begin
    int pe_cnt;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cur   = idle_rec();
    @(posedge clk);
    #1;
    do_reset();

    // Single operation: LSB sequence 1,0,1,1, product 11*13.
    run_op(4'd11, 4'd13, "op_11x13");
    run_op(4'd15, 4'd15, "op_15x15");

    // Zero multiplier: product_enable must stay low in RUN.
    op_a = 4'd9;
    op_b = 4'd0;
    clear_counts();
    pe_cnt = 0;
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle(i == 0, 1'b0);
      if (product_enable && shift_enable) pe_cnt++;
    end
    check_val("zero_pe_in_run", 32'(pe_cnt), 32'd0);
    check_val("zero_ready_cnt", 32'(ready_cnt), 32'd1);

    // Start pulse during RUN round 2 is ignored.
    op_a = 4'd7;
    op_b = 4'd5;
    clear_counts();
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    check_val("busy_start_ready_cnt", 32'(ready_cnt), 32'd1);

    // Start held high: one ready every WL+3 cycles.
    op_a = 4'd6;
    op_b = 4'd3;
    clear_counts();
    repeat (21) cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    check_val("held_ready_cnt", 32'(ready_cnt), 32'd3);
    if (ready_at.size() >= 3) begin
      check_val("held_gap1", 32'(ready_at[1] - ready_at[0]), 32'(WL + 3));
      check_val("held_gap2", 32'(ready_at[2] - ready_at[1]), 32'(WL + 3));
    end

    // Abort in RUN round 1: no ready.
    clear_counts();
    cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0);
    check_val("abort_run_ready_cnt", 32'(ready_cnt), 32'd0);

    // Abort in DONE: ready still seen in that cycle, then IDLE.
    clear_counts();
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    check_val("abort_done_ready_cnt", 32'(ready_cnt), 32'd1);

    // Abort together with start in IDLE: stays IDLE.
    clear_counts();
    cycle(1'b1, 1'b1);
    repeat (8) cycle(1'b0, 1'b0);
    check_val("abort_start_ready_cnt", 32'(ready_cnt), 32'd0);

    // Asynchronous reset mid-RUN.
    clear_counts();
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    do_reset();
    repeat (8) cycle(1'b0, 1'b0);
    check_val("reset_ready_cnt", 32'(ready_cnt), 32'd0);

    // Random start/abort traffic with random operands.
    for (int i = 0; i < 400; i++) begin
      logic st;
      logic ab;
      if (cur.kind == K_IDLE) begin
        op_a = WL'($urandom_range(0, (1 << WL) - 1));
        op_b = WL'($urandom_range(0, (1 << WL) - 1));
      end
      st = ($urandom_range(0, 2) == 0);
      ab = ($urandom_range(0, 15) == 0);
      cycle(st, ab);
    end
    repeat (8) cycle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
